// File: rtl/card_dealer.sv
// card_dealer: multi-deck shoe card source for the blackjack datapath.
// Draws cards without replacement from 13 per-rank counters using a free-running
// Galois LFSR with bounded rejection sampling, one or two cards per request.
// Optional build macro: CARD_DEALER_SCRIPT_EN adds scripted card sequences selected by `test`.
module card_dealer #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int          LOW_MARK  = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       two,
  input  logic       reshuffle,
  input  logic [2:0] test,
  output logic [3:0] card1_out,
  output logic [3:0] card2_out,
  output logic       valid,
  output logic       busy,
  output logic [8:0] cards_left,
  output logic       shoe_low
);

  localparam logic [5:0]  RANK_FULL = 6'(4 * NUM_DECKS);
  localparam logic [8:0]  SHOE_FULL = 9'(52 * NUM_DECKS);
  localparam logic [9:0]  LOW_LIMIT = 10'(LOW_MARK);
  localparam logic        LOW_INIT  = ({1'b0, SHOE_FULL} < LOW_LIMIT);
  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {IDLE, SHUFFLE, DRAW1, DRAW2} state_t;

  state_t      state, state_next;
  state_t      resume, resume_next;
  logic [15:0] lfsr;
  logic [12:0] rank_nz;
  logic [15:0] rank_nz_ext;
  logic [4:0]  rej_cnt;
  logic        two_held;
  logic [3:0]  held_card;
  logic [3:0]  cand;
  logic [3:0]  low_idx;
  logic [3:0]  take_idx;
  logic [3:0]  take_value;
  logic        cand_ok;
  logic        take;
  logic        do_shuffle;
  logic        do_take;
  logic        script_hit;
  logic [8:0]  cards_dec;

  // Rank index to blackjack value: A=1, 2..10 face value, J/Q/K=10
  function automatic logic [3:0] rank_value(input logic [3:0] idx);
    if (idx == 4'd0)
      return 4'd1;
    else if (idx <= 4'd9)
      return idx + 4'd1;
    else
      return 4'd10;
  endfunction

  // One counter per rank; each reports whether that rank is still stocked
  generate
    for (genvar gi = 0; gi < 13; gi++) begin : g_rank
      logic [5:0] cnt;

      // Refill on shuffle, decrement when this rank is the accepted draw
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          cnt <= RANK_FULL;
        else if (do_shuffle)
          cnt <= RANK_FULL;
        else if (do_take && (take_idx == 4'(gi)))
          cnt <= cnt - 6'd1;
      end

      assign rank_nz[gi] = (cnt != 6'd0);
    end
  endgenerate

  assign rank_nz_ext = {3'b000, rank_nz};
  assign busy        = (state != IDLE);
  assign cards_dec   = cards_left - 9'd1;

  // Free-running LFSR, advances every cycle independent of the FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      lfsr <= SEED;
    else
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  // Candidate acceptance, with fallback to the lowest stocked rank after 16 rejects
  always_comb begin
    cand    = lfsr[3:0];
    cand_ok = (cand <= 4'd12) && rank_nz_ext[cand];
    low_idx = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (rank_nz[i])
        low_idx = 4'(i);
    end
    take       = cand_ok || (rej_cnt == 5'd16);
    take_idx   = cand_ok ? cand : low_idx;
    take_value = rank_value(take_idx);
  end

  // FSM state register; resume remembers where an automatic shuffle returns to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      resume <= IDLE;
    end else begin
      state  <= state_next;
      resume <= resume_next;
    end
  end

  // FSM next state and per-cycle shuffle/draw strobes
  always_comb begin
    state_next  = state;
    resume_next = resume;
    do_shuffle  = 1'b0;
    do_take     = 1'b0;
    case (state)
      IDLE: begin
        if (reshuffle) begin
          state_next  = SHUFFLE;
          resume_next = IDLE;
        end else if (req && !script_hit) begin
          if (cards_left == 9'd0) begin
            state_next  = SHUFFLE;
            resume_next = DRAW1;
          end else begin
            state_next = DRAW1;
          end
        end
      end
      SHUFFLE: begin
        do_shuffle = 1'b1;
        state_next = resume;
      end
      DRAW1: begin
        if (take) begin
          do_take = 1'b1;
          if (!two_held) begin
            state_next = IDLE;
          end else if (cards_left == 9'd1) begin
            // Second card would enter DRAW2 with an empty shoe
            state_next  = SHUFFLE;
            resume_next = DRAW2;
          end else begin
            state_next = DRAW2;
          end
        end
      end
      DRAW2: begin
        if (take) begin
          do_take    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shoe totals, reject counter and the held first card of a double deal
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cards_left <= SHOE_FULL;
      shoe_low   <= LOW_INIT;
      rej_cnt    <= 5'd0;
      two_held   <= 1'b0;
      held_card  <= 4'd0;
    end else begin
      if (do_shuffle) begin
        cards_left <= SHOE_FULL;
        shoe_low   <= LOW_INIT;
      end else if (do_take) begin
        cards_left <= cards_dec;
        shoe_low   <= ({1'b0, cards_dec} < LOW_LIMIT);
      end
      if (((state == DRAW1) || (state == DRAW2)) && !take)
        rej_cnt <= rej_cnt + 5'd1;
      else
        rej_cnt <= 5'd0;
      if ((state == IDLE) && req)
        two_held <= two;
      if ((state == DRAW1) && take)
        held_card <= take_value;
    end
  end

`ifdef CARD_DEALER_SCRIPT_EN
  logic [2:0] script_idx;
  logic [2:0] script_prev_test;
  logic [2:0] script_eff;

  // Scripted (card1, card2) pair for a given sequence and step
  function automatic logic [7:0] script_step(input logic [2:0] sel, input logic [2:0] idx);
    logic [7:0] pair;
    pair = 8'h00;
    case (sel)
      3'd1: pair = (idx == 3'd0) ? {4'd10, 4'd8} : {4'd4, 4'd0};
      3'd2: pair = (idx == 3'd0) ? {4'd10, 4'd8} : {4'd2, 4'd0};
      3'd3: pair = {4'd10, 4'd1};
      3'd4: begin
        case (idx)
          3'd0:    pair = {4'd10, 4'd10};
          3'd1:    pair = {4'd8, 4'd0};
          3'd2:    pair = {4'd4, 4'd0};
          3'd3:    pair = {4'd8, 4'd0};
          default: pair = {4'd2, 4'd0};
        endcase
      end
      default: pair = 8'h00;
    endcase
    return pair;
  endfunction

  // Number of steps before a script wraps
  function automatic logic [2:0] script_len(input logic [2:0] sel);
    case (sel)
      3'd1, 3'd2: return 3'd2;
      3'd4:       return 3'd5;
      default:    return 3'd1;
    endcase
  endfunction

  assign script_hit = (state == IDLE) && !reshuffle && req && (test != 3'd0);
  assign script_eff = (test != script_prev_test) ? 3'd0 : script_idx;

  // Script step index; a change of test restarts the sequence
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      script_idx       <= 3'd0;
      script_prev_test <= 3'd0;
    end else begin
      script_prev_test <= test;
      if (script_hit)
        script_idx <= ((script_eff + 3'd1) == script_len(test)) ? 3'd0 : script_eff + 3'd1;
      else
        script_idx <= script_eff;
    end
  end
`else
  logic unused_test;

  assign script_hit  = 1'b0;
  assign unused_test = ^test;
`endif

  // Card outputs and the one-cycle valid pulse; cards hold until the next valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      card1_out <= 4'd0;
      card2_out <= 4'd0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      if ((state == DRAW1) && take && !two_held) begin
        card1_out <= take_value;
        card2_out <= 4'd0;
        valid     <= 1'b1;
      end else if ((state == DRAW2) && take) begin
        card1_out <= held_card;
        card2_out <= take_value;
        valid     <= 1'b1;
      end
`ifdef CARD_DEALER_SCRIPT_EN
      else if (script_hit) begin
        {card1_out, card2_out} <= script_step(test, script_eff);
        valid                  <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// tb_card_dealer: directed self-checking bench for card_dealer (1-deck and 8-deck shoes).
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       two;
  logic       reshuffle;
  logic [2:0] test;
  logic [3:0] card1_out;
  logic [3:0] card2_out;
  logic       valid;
  logic       busy;
  logic [8:0] cards_left;
  logic       shoe_low;

  logic       req8;
  logic [3:0] card1_8;
  logic [3:0] card2_8;
  logic       valid8;
  logic       busy8;
  logic [8:0] cards_left8;
  logic       shoe_low8;

  int n_checks = 0;
  int n_fail   = 0;
  int tally[16];
  int tally8[16];

  always #5 clk = ~clk;

  card_dealer #(.NUM_DECKS(1)) dut (
    .clk(clk), .reset(reset), .req(req), .two(two), .reshuffle(reshuffle), .test(test),
    .card1_out(card1_out), .card2_out(card2_out), .valid(valid), .busy(busy),
    .cards_left(cards_left), .shoe_low(shoe_low)
  );

  card_dealer #(.NUM_DECKS(8)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .two(1'b0), .reshuffle(1'b0), .test(3'd0),
    .card1_out(card1_8), .card2_out(card2_8), .valid(valid8), .busy(busy8),
    .cards_left(cards_left8), .shoe_low(shoe_low8)
  );

  // Single comparison point: counts, and reports any mismatch
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one request; lat = edges after the request edge until valid (40 = timed out)
  task automatic deal(input bit big, input bit dbl, output int lat, output bit bsy);
    @(negedge clk);
    if (big) req8 = 1'b1;
    else begin
      req = 1'b1;
      two = dbl;
    end
    @(negedge clk);
    req  = 1'b0;
    two  = 1'b0;
    req8 = 1'b0;
    bsy  = big ? busy8 : busy;
    lat  = 0;
    while (!(big ? valid8 : valid) && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lat;
    bit  bsy;
    int  vcount;
    int  n;
    int  maxlat;
    int  bad;
    int  c1;
    int  c2;

    reset = 1'b1; req = 1'b0; two = 1'b0; reshuffle = 1'b0; test = 3'd0; req8 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tally[i]  = 0;
      tally8[i] = 0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_cards_left", int'(cards_left), 52);
    check("rst_card1", int'(card1_out), 0);
    check("rst_card2", int'(card2_out), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_shoe_low", int'(shoe_low), 0);
    check("rst_cards_left8", int'(cards_left8), 416);

    // First single deal
    deal(1'b0, 1'b0, lat, bsy);
    $display("deal 1: lat=%0d card1=%0d card2=%0d left=%0d", lat, card1_out, card2_out, cards_left);
    check("first_busy", int'(bsy), 1);
    check("first_lat", int'(lat >= 1 && lat <= 17), 1);
    check("first_card_range", int'(card1_out >= 1 && card1_out <= 10), 1);
    check("first_card2", int'(card2_out), 0);
    check("first_left", int'(cards_left), 51);
    check("first_busy_fall", int'(busy), 0);
    tally[card1_out]++;

    // Drain the rest of the shoe
    for (int k = 2; k <= 52; k++) begin
      deal(1'b0, 1'b0, lat, bsy);
      $display("deal %0d: lat=%0d card1=%0d left=%0d low=%0d", k, lat, card1_out, cards_left, shoe_low);
      check("drain_lat", int'(lat >= 1 && lat <= 17), 1);
      check("drain_range", int'(card1_out >= 1 && card1_out <= 10), 1);
      check("drain_card2", int'(card2_out), 0);
      check("drain_left", int'(cards_left), 52 - k);
      check("drain_shoe_low", int'(shoe_low), int'((52 - k) < 15));
      tally[card1_out]++;
    end
    for (int v = 1; v <= 10; v++)
      check($sformatf("tally_value_%0d", v), tally[v], (v == 10) ? 16 : 4);

    // Empty shoe: next request shuffles automatically, then deals
    deal(1'b0, 1'b0, lat, bsy);
    $display("deal 53: lat=%0d card1=%0d left=%0d", lat, card1_out, cards_left);
    check("auto_lat", int'(lat >= 2 && lat <= 18), 1);
    check("auto_range", int'(card1_out >= 1 && card1_out <= 10), 1);
    check("auto_left", int'(cards_left), 51);
    check("auto_shoe_low", int'(shoe_low), 0);

    // reshuffle wins over a simultaneous req
    @(negedge clk);
    reshuffle = 1'b1;
    req = 1'b1;
    @(negedge clk);
    reshuffle = 1'b0;
    req = 1'b0;
    check("rs_busy", int'(busy), 1);
    vcount = int'(valid);
    repeat (20) begin
      @(negedge clk);
      if (valid) vcount++;
    end
    $display("reshuffle+req: valids=%0d left=%0d", vcount, cards_left);
    check("rs_no_valid", vcount, 0);
    check("rs_left", int'(cards_left), 52);
    check("rs_idle", int'(busy), 0);

    // Double deal with a stray req while busy
    @(negedge clk);
    req = 1'b1;
    two = 1'b1;
    @(negedge clk);
    req = 1'b0;
    two = 1'b0;
    check("dbl_busy", int'(busy), 1);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    vcount = 0;
    c1 = 0;
    c2 = 0;
    repeat (80) begin
      if (valid) begin
        vcount++;
        c1 = int'(card1_out);
        c2 = int'(card2_out);
      end
      @(negedge clk);
    end
    $display("double deal: valids=%0d card1=%0d card2=%0d left=%0d", vcount, c1, c2, cards_left);
    check("dbl_one_valid", vcount, 1);
    check("dbl_card1_range", int'(c1 >= 1 && c1 <= 10), 1);
    check("dbl_card2_range", int'(c2 >= 1 && c2 <= 10), 1);
    check("dbl_left", int'(cards_left), 50);

    // Reset while the second card of a double deal is pending
    @(negedge clk);
    req = 1'b1;
    two = 1'b1;
    @(negedge clk);
    req = 1'b0;
    two = 1'b0;
    n = 0;
    while (!(cards_left == 9'd49 && !valid) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("d2_reached", int'(n < 40), 1);
    #2 reset = 1'b1;
    #1;
    $display("reset in DRAW2: card1=%0d card2=%0d busy=%0d left=%0d", card1_out, card2_out, busy, cards_left);
    check("d2rst_card1", int'(card1_out), 0);
    check("d2rst_card2", int'(card2_out), 0);
    check("d2rst_valid", int'(valid), 0);
    check("d2rst_busy", int'(busy), 0);
    check("d2rst_left", int'(cards_left), 52);
    @(negedge clk);
    reset = 1'b0;

`ifdef CARD_DEALER_SCRIPT_EN
    begin
      int s1[6];
      int s2[6];
      s1 = '{10, 8, 4, 8, 2, 10};
      s2 = '{10, 0, 0, 0, 0, 10};
      test = 3'd4;
      for (int i = 0; i < 6; i++) begin
        deal(1'b0, 1'b0, lat, bsy);
        $display("script step %0d: lat=%0d card1=%0d card2=%0d", i, lat, card1_out, card2_out);
        check("script_lat", lat, 0);
        check("script_card1", int'(card1_out), s1[i]);
        check("script_card2", int'(card2_out), s2[i]);
      end
      check("script_left", int'(cards_left), 52);
      test = 3'd0;
    end
`endif

    // Eight-deck shoe: deal every card
    maxlat = 0;
    bad = 0;
    for (int k = 1; k <= 416; k++) begin
      deal(1'b1, 1'b0, lat, bsy);
      $display("deal8 %0d: lat=%0d card1=%0d left=%0d", k, lat, card1_8, cards_left8);
      if (lat > maxlat) maxlat = lat;
      if (card1_8 < 4'd1 || card1_8 > 4'd10 || card2_8 != 4'd0) bad++;
      tally8[card1_8]++;
    end
    check("d8_maxlat", int'(maxlat <= 17), 1);
    check("d8_bad_outputs", bad, 0);
    check("d8_left", int'(cards_left8), 0);
    check("d8_shoe_low", int'(shoe_low8), 1);
    for (int v = 1; v <= 10; v++)
      check($sformatf("d8_tally_value_%0d", v), tally8[v], (v == 10) ? 128 : 32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
